// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared widths, synchroniser reset levels and helpers for the SPI slave PHY
package spi_pkg;

    localparam int SPI_BYTE_W    = 8;
    localparam int SPI_BIT_CNT_W = 3;

    // Idle levels of the raw pins: clock low (mode 0), data low, chip select released.
    localparam logic SCLK_RST_VAL = 1'b0;
    localparam logic MOSI_RST_VAL = 1'b0;
    localparam logic CS_N_RST_VAL = 1'b1;

    localparam logic [SPI_BIT_CNT_W-1:0] LAST_BIT = SPI_BIT_CNT_W'(SPI_BYTE_W - 1);

    typedef logic [SPI_BYTE_W-1:0]    spi_byte_t;
    typedef logic [SPI_BIT_CNT_W-1:0] spi_bit_cnt_t;

    // MSB-first shift: new bit enters at the LSB end.
    function automatic spi_byte_t shift_in(input spi_byte_t cur, input logic bit_in);
        return {cur[SPI_BYTE_W-2:0], bit_in};
    endfunction

endpackage

// File: rtl/spi_slave_phy_if.sv
// rtl/spi_slave_phy_if.sv - SPI pin and byte-side bundle; SPI_SLAVE_PHY_STATUS_EN adds byte_cnt/frame_err
interface spi_slave_phy_if;
    import spi_pkg::*;

    logic      spi_sclk;
    logic      spi_mosi;
    logic      spi_cs_n;
    logic      spi_miso;
    spi_byte_t tx_byte;
    spi_byte_t rx_byte;
    logic      rx_valid;
    logic      cs_sync;

`ifdef SPI_SLAVE_PHY_STATUS_EN
    logic [7:0] byte_cnt;
    logic       frame_err;

    modport slave (
        input  spi_sclk, spi_mosi, spi_cs_n, tx_byte,
        output spi_miso, rx_byte, rx_valid, cs_sync, byte_cnt, frame_err
    );

    modport master (
        output spi_sclk, spi_mosi, spi_cs_n, tx_byte,
        input  spi_miso, rx_byte, rx_valid, cs_sync, byte_cnt, frame_err
    );
`else
    modport slave (
        input  spi_sclk, spi_mosi, spi_cs_n, tx_byte,
        output spi_miso, rx_byte, rx_valid, cs_sync
    );

    modport master (
        output spi_sclk, spi_mosi, spi_cs_n, tx_byte,
        input  spi_miso, rx_byte, rx_valid, cs_sync
    );
`endif

endinterface

// File: rtl/spi_slave_phy_sync_edge.sv
// rtl/spi_slave_phy_sync_edge.sv - multi-flop pin synchroniser with registered-previous edge detect
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_prev;

    // Shift the raw pin through the chain; r_prev trails the synchronised value by one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= {SYNC_STAGES{RST_VAL}};
            r_prev  <= RST_VAL;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_pin};
            r_prev  <= r_chain[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];
    assign o_rise = !r_prev &&  o_sync;
    assign o_fall =  r_prev && !o_sync;

endmodule

// File: rtl/spi_slave_phy.sv
// rtl/spi_slave_phy.sv - SPI mode-0 slave PHY; SPI_SLAVE_PHY_STATUS_EN adds byte_cnt/frame_err outputs
module spi_slave_phy
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    spi_slave_phy_if.slave  bus
);

    logic w_sclk_s;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_mosi_s;
    logic w_mosi_rise;
    logic w_mosi_fall;
    logic w_cs_s;
    logic w_cs_rise;
    logic w_cs_fall;

    spi_bit_cnt_t r_bit_cnt;
    spi_byte_t    r_rx_shift;
    spi_byte_t    r_tx_shift;
    logic         r_byte_done;
    spi_byte_t    r_rx_byte;
    logic         r_rx_valid;
    logic         r_miso;

    spi_byte_t    w_tx_next;
    spi_byte_t    w_rx_next;
    logic         w_rise_act;
    logic         w_fall_act;
    logic         w_byte_end;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (SCLK_RST_VAL)
    ) u_sync_sclk (
        .clk    (clk),
        .rst    (rst),
        .i_pin  (bus.spi_sclk),
        .o_sync (w_sclk_s),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (MOSI_RST_VAL)
    ) u_sync_mosi (
        .clk    (clk),
        .rst    (rst),
        .i_pin  (bus.spi_mosi),
        .o_sync (w_mosi_s),
        .o_rise (w_mosi_rise),
        .o_fall (w_mosi_fall)
    );

    // The cs chain resets to 1, so after rst cs_sync stays deselected until the chain refills.
    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (CS_N_RST_VAL)
    ) u_sync_cs (
        .clk    (clk),
        .rst    (rst),
        .i_pin  (bus.spi_cs_n),
        .o_sync (w_cs_s),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    // Level of sclk is only needed for its edges; mosi edges and (in the base build) cs edges go nowhere.
    logic w_unused;
    assign w_unused = ^{w_sclk_s, w_mosi_rise, w_mosi_fall, w_cs_rise, w_cs_fall};

    // Edges count only while selected; deselect therefore wins over a coincident rise.
    always_comb begin
        w_rise_act = !w_cs_s && w_sclk_rise;
        w_fall_act = !w_cs_s && w_sclk_fall;
        w_byte_end = w_rise_act && (r_bit_cnt == LAST_BIT);
        w_rx_next  = shift_in(r_rx_shift, w_mosi_s);
    end

    // Next transmit shifter: track tx_byte while idle, reload after a byte, else shift left.
    always_comb begin
        w_tx_next = r_tx_shift;
        if (w_cs_s) begin
            w_tx_next = bus.tx_byte;
        end else if (w_fall_act) begin
            if (r_byte_done) begin
                w_tx_next = bus.tx_byte;
            end else begin
                w_tx_next = {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
            end
        end
    end

    // Receive path: sample mosi on each rise, publish the byte and strobe after the eighth bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_rx_byte   <= '0;
            r_rx_valid  <= 1'b0;
            r_byte_done <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_cs_s) begin
                r_bit_cnt   <= '0;
                r_byte_done <= 1'b0;
            end else if (w_rise_act) begin
                r_rx_shift <= w_rx_next;
                r_bit_cnt  <= r_bit_cnt + 1'b1;
                if (w_byte_end) begin
                    r_rx_byte   <= w_rx_next;
                    r_rx_valid  <= 1'b1;
                    r_byte_done <= 1'b1;
                end
            end else if (w_fall_act && r_byte_done) begin
                r_byte_done <= 1'b0;
            end
        end
    end

    // Transmit path: MISO is a flop fed from the next shifter MSB, held low while deselected.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_shift <= '0;
            r_miso     <= 1'b0;
        end else begin
            r_tx_shift <= w_tx_next;
            r_miso     <= w_cs_s ? 1'b0 : w_tx_next[SPI_BYTE_W-1];
        end
    end

    assign bus.spi_miso = r_miso;
    assign bus.rx_byte  = r_rx_byte;
    assign bus.rx_valid = r_rx_valid;
    assign bus.cs_sync  = w_cs_s;

`ifdef SPI_SLAVE_PHY_STATUS_EN
    logic [7:0] r_byte_cnt;
    logic       r_frame_err;

    // Per-frame byte counter (saturating) and sticky flag for frames ending mid-byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt  <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_cs_fall) begin
                r_byte_cnt <= '0;
            end else if (w_byte_end && (r_byte_cnt != 8'hFF)) begin
                r_byte_cnt <= r_byte_cnt + 8'd1;
            end
            if (w_cs_rise && (r_bit_cnt != '0)) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign bus.byte_cnt  = r_byte_cnt;
    assign bus.frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_spi_slave_phy.sv
// tb/tb_spi_slave_phy.sv - self-checking bench for spi_slave_phy
module tb_spi_slave_phy;

    localparam int SYNC = 2;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_phy_if bus();

    spi_slave_phy #(.SYNC_STAGES(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rise8_cyc = 0;
    logic [7:0] rx_q[$];
    logic [7:0] resp_q[$];

    typedef struct {
        bit         start;
        bit         last;
        logic [7:0] init;
        logic [7:0] mosi;
        logic [7:0] resp;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Host side of a mode-0 transfer; MISO is sampled just before each rising edge.
    task automatic xfer(input logic [7:0] d, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            bus.spi_mosi = d[7-b];
            wait_clk(HALF);
            mi = {mi[6:0], bus.spi_miso};
            if (b == 7) begin
                rise8_cyc = cyc;
                rx_q.push_back(d);
            end
            bus.spi_sclk = 1'b1;
            wait_clk(HALF);
            bus.spi_sclk = 1'b0;
        end
    endtask

    // Scoreboard pop on each rx_valid, plus the bus-FSM model supplying the next response byte.
    always @(negedge clk) begin
        if (!rst && bus.rx_valid === 1'b1) begin
            if (rx_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rx_unexpected got=%02h exp=no_pulse", bus.rx_byte);
            end else begin
                check("rx_byte", bus.rx_byte, rx_q.pop_front());
            end
            check("rx_latency", cyc - rise8_cyc, SYNC + 1);
            if (resp_q.size() != 0) bus.tx_byte = resp_q.pop_front();
        end
    end

    initial begin
        logic [7:0] mi;

        vecs[0] = '{1'b1, 1'b0, 8'h00, 8'h85, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 8'hC3, 8'h3C, 8'hA5};
        vecs[2] = '{1'b1, 1'b0, 8'h5A, 8'h11, 8'h96, 8'h5A};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 8'h22, 8'h0F, 8'h96};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 8'h33, 8'hF0, 8'h0F};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h44, 8'h00, 8'hF0};

        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_cs_n = 1'b0;
        bus.tx_byte  = 8'h00;
        rst = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_cs_sync", bus.cs_sync, 1);
            check("rst_rx_valid", bus.rx_valid, 0);
            check("rst_miso", bus.spi_miso, 0);
            bus.spi_sclk = ~bus.spi_sclk;
        end
        @(negedge clk);
        bus.spi_sclk = 1'b0;
        rst = 1'b0;
        for (int k = 1; k <= SYNC; k++) begin
            @(negedge clk);
            if (k < SYNC) check("refill_cs_sync", bus.cs_sync, 1);
            check("refill_rx_valid", bus.rx_valid, 0);
            check("refill_miso", bus.spi_miso, 0);
        end
        check("rst_rx_byte", bus.rx_byte, 8'h00);
`ifdef SPI_SLAVE_PHY_STATUS_EN
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_byte_cnt", bus.byte_cnt, 0);
`endif
        bus.spi_cs_n = 1'b1;
        wait_clk(2 * HALF);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].start) begin
                bus.tx_byte  = vecs[v].init;
                bus.spi_cs_n = 1'b0;
                wait_clk(HALF);
            end
            resp_q.push_back(vecs[v].resp);
            xfer(vecs[v].mosi, 8, mi);
            check($sformatf("miso_vec%0d", v), mi, vecs[v].exp_miso);
            if (vecs[v].last) begin
                wait_clk(HALF);
                bus.spi_cs_n = 1'b1;
                wait_clk(2 * HALF);
                check("deselect_cs_sync", bus.cs_sync, 1);
                check("deselect_miso", bus.spi_miso, 0);
            end
        end
        check("table_rx_q_empty", rx_q.size(), 0);
        check("table_rx_byte", bus.rx_byte, 8'h44);
`ifdef SPI_SLAVE_PHY_STATUS_EN
        check("table_byte_cnt", bus.byte_cnt, 4);
        check("table_frame_err", bus.frame_err, 0);
`endif

        // One full byte, then deselect after 5 bits of 0xFF.
        bus.tx_byte  = 8'h00;
        bus.spi_cs_n = 1'b0;
        wait_clk(HALF);
        resp_q.push_back(8'h00);
        xfer(8'h5C, 8, mi);
        check("partial_first_miso", mi, 8'h00);
        xfer(8'hFF, 5, mi);
        wait_clk(HALF);
        bus.spi_cs_n = 1'b1;
        wait_clk(3 * HALF);
        check("partial_cs_sync", bus.cs_sync, 1);
        check("partial_rx_byte", bus.rx_byte, 8'h5C);
        check("partial_rx_q_empty", rx_q.size(), 0);
`ifdef SPI_SLAVE_PHY_STATUS_EN
        check("partial_frame_err", bus.frame_err, 1);
        check("partial_byte_cnt", bus.byte_cnt, 1);
`endif

        // Eighth rising edge arrives together with deselect: the deselect must win.
        bus.spi_cs_n = 1'b0;
        wait_clk(HALF);
        xfer(8'hAA, 7, mi);
        bus.spi_mosi = 1'b0;
        wait_clk(HALF);
        bus.spi_sclk = 1'b1;
        bus.spi_cs_n = 1'b1;
        wait_clk(HALF);
        bus.spi_sclk = 1'b0;
        wait_clk(3 * HALF);
        check("simul_rx_byte", bus.rx_byte, 8'h5C);
        check("simul_cs_sync", bus.cs_sync, 1);

        // Reset three bits into a frame, then a clean byte with cs still asserted.
        bus.tx_byte  = 8'h00;
        bus.spi_cs_n = 1'b0;
        wait_clk(HALF);
        xfer(8'hE7, 3, mi);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_cs_sync", bus.cs_sync, 1);
            check("midrst_miso", bus.spi_miso, 0);
        end
        rst = 1'b0;
        wait_clk(HALF);
        check("midrst_rx_byte", bus.rx_byte, 8'h00);
        check("midrst_cs_refill", bus.cs_sync, 0);
`ifdef SPI_SLAVE_PHY_STATUS_EN
        check("midrst_frame_err", bus.frame_err, 0);
`endif
        resp_q.push_back(8'h00);
        xfer(8'h3C, 8, mi);
        wait_clk(HALF);
        check("midrst_clean_rx_byte", bus.rx_byte, 8'h3C);
`ifdef SPI_SLAVE_PHY_STATUS_EN
        check("midrst_byte_cnt", bus.byte_cnt, 1);
`endif
        bus.spi_cs_n = 1'b1;
        wait_clk(3 * HALF);
        check("final_rx_q_empty", rx_q.size(), 0);
        check("final_cs_sync", bus.cs_sync, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
